// File: rtl/lift_pkg.sv
// lift_pkg: lift state encoding and default FLOORS/T_MOVE/T_DOOR constants shared by the lift blocks
package lift_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
  localparam int FLOORS_DEF = 4;
  localparam int T_MOVE_DEF = 2;
  localparam int T_DOOR_DEF = 3;
  localparam int TIMER_W = 8;
endpackage

// File: rtl/sec_tick_sync.sv
// sec_tick_sync: synchronises clk_1s (in) to clk_100MHz (in, rst_n sync active-low) and emits a registered one-cycle sec_tick (out) per rising edge
module sec_tick_sync (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic clk_1s,
  output logic sec_tick
);
  logic s1, s2, hist;
  always_ff @(posedge clk_100MHz)
    if (!rst_n) {s1, s2, hist, sec_tick} <= 4'b1110;
    else begin
      s1       <= clk_1s;
      s2       <= s1;
      hist     <= s2;
      sec_tick <= s2 & ~hist;
    end
endmodule

// File: rtl/lift_car_fsm.sv
// lift_car_fsm: SCAN lift car controller; in clk_100MHz, rst_n, clk_1s, req[FLOORS]; out floor, dir_up, moving, door_open, pending[FLOORS], sec_tick
module lift_car_fsm
  import lift_pkg::*;
#(
  parameter int FLOORS  = FLOORS_DEF,
  parameter int FLOOR_W = 2,
  parameter int T_MOVE  = T_MOVE_DEF,
  parameter int T_DOOR  = T_DOOR_DEF
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic               clk_1s,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic               sec_tick
);
  state_t state, state_n;
  logic [FLOOR_W-1:0] floor_n, nf;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [FLOORS-1:0] clr;
  logic dir_n, a_c, b_c, a_n, b_n, up_c, dn_c, up_n, dn_n;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    return |((p >> f) >> 1);
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    return |(p & ((FLOORS'(1) << f) - FLOORS'(1)));
  endfunction

  sec_tick_sync u_tick (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .clk_1s    (clk_1s),
    .sec_tick  (sec_tick)
  );

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = state == DOOR;

  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n   = dir_up;
    timer_n = timer;
    clr     = '0;
    nf      = (state == MOVE_UP) ? floor + 1'b1 : floor - 1'b1;
    a_c     = any_above(pending, floor);
    b_c     = any_below(pending, floor);
    a_n     = any_above(pending, nf);
    b_n     = any_below(pending, nf);
    // keep the preferred direction while it still has work, else turn round
    up_c    = a_c & (dir_up | ~b_c);
    dn_c    = b_c & ~up_c;
    up_n    = a_n & (dir_up | ~b_n);
    dn_n    = b_n & ~up_n;
    case (state)
      IDLE:
        if (pending[floor]) begin
          state_n    = DOOR;
          clr[floor] = 1'b1;
        end else if (a_c) begin
          state_n = MOVE_UP;
          dir_n   = 1'b1;
        end else if (b_c) begin
          state_n = MOVE_DOWN;
          dir_n   = 1'b0;
        end
      MOVE_UP, MOVE_DOWN:
        if (sec_tick) begin
          if (timer == TIMER_W'(T_MOVE - 1)) begin
            floor_n = nf;
            timer_n = '0;
            if (pending[nf]) begin
              state_n = DOOR;
              clr[nf] = 1'b1;
            end else begin
              state_n = up_n ? MOVE_UP : dn_n ? MOVE_DOWN : IDLE;
              dir_n   = up_n | (~dn_n & dir_up);
            end
          end else timer_n = timer + 1'b1;
        end
      DOOR: begin
        // a call at the open floor is absorbed and keeps the door open
        clr[floor] = 1'b1;
        if (req[floor]) timer_n = '0;
        else if (sec_tick) begin
          if (timer == TIMER_W'(T_DOOR - 1)) begin
            timer_n = '0;
            state_n = up_c ? MOVE_UP : dn_c ? MOVE_DOWN : IDLE;
            dir_n   = up_c | (~dn_c & dir_up);
          end else timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz)
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= '0;
      dir_up  <= 1'b1;
      pending <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir_up  <= dir_n;
      pending <= (pending | req) & ~clr;
      timer   <= timer_n;
    end
endmodule

// File: tb/tb_lift_car_fsm.sv
// tb_lift_car_fsm: randomized and directed self-checking bench for lift_car_fsm against a tick-counting behavioural model
module tb_lift_car_fsm;
  localparam int T_MOVE = 2;
  localparam int T_DOOR = 3;

  logic clk = 0, rst_n = 0, clk_1s = 1;
  logic [3:0] req = '0;
  logic [1:0] floor;
  logic dir_up, moving, door_open, sec_tick;
  logic [3:0] pending;
  int checks = 0, failures = 0;

  lift_car_fsm dut (
    .clk_100MHz(clk),
    .rst_n     (rst_n),
    .clk_1s    (clk_1s),
    .req       (req),
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending),
    .sec_tick  (sec_tick)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (10) @(posedge clk);
    #2 clk_1s = ~clk_1s;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // model: mode 0 idle, 1 up, 2 down, 3 door; m_t counts elapsed ticks
  int m_floor = 0, m_mode = 0, m_t = 0;
  bit m_dir = 1, m_tick = 0, model_live = 0;
  bit [3:0] m_pend = '0, samp = 4'hF;

  function automatic int pick(input bit pref, input int f, input bit [3:0] p);
    int na = 0, nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && i > f) na++;
      if (p[i] && i < f) nb++;
    end
    if (na > 0 && (pref || nb == 0)) return 1;
    if (nb > 0) return 2;
    return 0;
  endfunction

  task automatic leave(input int d);
    m_mode = d;
    if (d != 0) m_dir = (d == 1);
  endtask

  task automatic model_step;
    bit tk;
    bit [3:0] served;
    if (!rst_n) begin
      m_floor = 0; m_mode = 0; m_t = 0; m_dir = 1; m_pend = '0; samp = 4'hF; m_tick = 0;
      return;
    end
    tk = m_tick;
    served = '0;
    samp = {samp[2:0], clk_1s};
    m_tick = samp[2] & ~samp[3];
    case (m_mode)
      0: if (m_pend[m_floor]) begin
           m_mode = 3;
           served[m_floor] = 1;
         end else leave(pick(1, m_floor, m_pend));
      1, 2: if (tk) begin
           m_t++;
           if (m_t == T_MOVE) begin
             m_t = 0;
             m_floor += (m_mode == 1) ? 1 : -1;
             if (m_pend[m_floor]) begin
               m_mode = 3;
               served[m_floor] = 1;
             end else leave(pick(m_dir, m_floor, m_pend));
           end
         end
      default: begin
        served[m_floor] = 1;
        if (req[m_floor]) m_t = 0;
        else if (tk) begin
          m_t++;
          if (m_t == T_DOOR) begin
            m_t = 0;
            leave(pick(m_dir, m_floor, m_pend));
          end
        end
      end
    endcase
    m_pend = (m_pend | req) & ~served;
  endtask

  always @(posedge clk) begin
    model_step();
    model_live = 1;
  end

  always @(negedge clk) if (model_live) begin
    logic [9:0] got, exp_v;
    assert (m_floor >= 0 && m_floor <= 3) else $error("FAIL floor_range model floor=%0d", m_floor);
    got   = {floor, dir_up, moving, door_open, pending, sec_tick};
    exp_v = {2'(m_floor), m_dir, (m_mode == 1 || m_mode == 2), (m_mode == 3), m_pend, m_tick};
    checks++;
    if (got !== exp_v) begin
      failures++;
      if (failures < 20)
        $display("FAIL model_cmp t=%0t got floor=%0d dir=%b mov=%b door=%b pend=%b tick=%b want floor=%0d dir=%b mov=%b door=%b pend=%b tick=%b",
                 $time, floor, dir_up, moving, door_open, pending, sec_tick,
                 m_floor, m_dir, (m_mode == 1 || m_mode == 2), (m_mode == 3), m_pend, m_tick);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    @(posedge clk); #2 req = v;
    @(posedge clk); #2 req = '0;
  endtask

  task automatic wait_for(input int what, input int budget, input string name);
    int n = 0;
    bit ok = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      case (what)
        0: ok = (door_open === 1'b1);
        1: ok = (door_open === 1'b0);
        2: ok = (moving === 1'b0 && door_open === 1'b0);
        default: ok = (moving === 1'b1 && floor === 2'd1);
      endcase
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_%s waited=%0d cycles", name, n);
    end
  endtask

  initial begin
    int n, tks, last, gap, code;
    int seq[$];
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_floor", floor, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tick", sec_tick, 0);

    n = 0; tks = 0;
    while (clk_1s !== 1'b0 && n < 100) begin @(negedge clk); n++; tks += sec_tick; end
    while (clk_1s !== 1'b1 && n < 100) begin @(negedge clk); n++; tks += sec_tick; end
    chk("no_false_tick", tks, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) chk("tick_early", sec_tick, 0);
    @(negedge clk) chk("tick_3clk", sec_tick, 1);
    @(negedge clk) chk("tick_width", sec_tick, 0);

    pulse(4'b0001);
    @(negedge clk);
    chk("here_latched", pending, 4'b0001);
    chk("here_door_wait", door_open, 0);
    @(negedge clk);
    chk("here_door", door_open, 1);
    chk("here_cleared", pending, 0);
    n = 0; tks = 0;
    while (door_open === 1'b1 && n < 200) begin tks += sec_tick; @(negedge clk); n++; end
    chk("door_ticks", tks, 3);
    chk("idle_after_door", {moving, door_open, pending}, 0);

    wait_for(2, 300, "idle_s3");
    pulse(4'b1000);
    n = 0; tks = 0; last = 0; gap = -1; seq.delete();
    while (door_open !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (sec_tick) tks++;
      if (moving === 1'b1 && dir_up !== 1'b1) chk("up_dir", dir_up, 1);
      if (int'(floor) != last) begin
        seq.push_back(int'(floor));
        if (floor == 2'd3) gap = tks;
        tks = 0;
        last = int'(floor);
      end
    end
    code = (seq.size() == 3) ? seq[0] * 100 + seq[1] * 10 + seq[2] : -1;
    chk("up_seq", code, 123);
    chk("up_gap_ticks", gap, 2);
    chk("up_door_floor", floor, 3);
    chk("up_dir_end", dir_up, 1);
    chk("up_pending", pending, 0);

    pulse(4'b0101);
    @(negedge clk) chk("down_latched", pending, 4'b0101);
    wait_for(1, 200, "s4_close3");
    wait_for(0, 400, "s4_open2");
    chk("down_first", floor, 2);
    chk("down_dir1", dir_up, 0);
    wait_for(1, 200, "s4_close2");
    wait_for(0, 400, "s4_open0");
    chk("down_second", floor, 0);
    chk("down_dir2", dir_up, 0);
    chk("down_pending", pending, 0);

    wait_for(2, 300, "idle_s5");
    pulse(4'b1000);
    wait_for(3, 400, "at1_s5");
    pulse(4'b0101);
    wait_for(0, 400, "scan_a");
    chk("scan_first", floor, 2);
    chk("scan_dir", dir_up, 1);
    wait_for(1, 200, "scan_close_a");
    wait_for(0, 400, "scan_b");
    chk("scan_second", floor, 3);
    wait_for(1, 200, "scan_close_b");
    wait_for(0, 600, "scan_c");
    chk("scan_third", floor, 0);
    chk("scan_dir_rev", dir_up, 0);

    wait_for(2, 300, "idle_s6");
    pulse(4'b1000);
    wait_for(3, 400, "at1_s6");
    repeat (5) @(negedge clk);
    chk("mid_move", {moving, floor}, {1'b1, 2'd1});
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("rst_mid_all", {floor, moving, door_open, pending, dir_up}, 9'b000000001);

    repeat (4000) begin
      @(posedge clk);
      #2;
      rst_n = ($urandom_range(0, 1499) != 0);
      req = ($urandom_range(0, 29) == 0) ? (($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom)) : 4'h0;
    end
    @(posedge clk); #2 rst_n = 1; req = '0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
